// File: rtl/register_bank_if.sv
// Write/read port bundle for register_bank: one write port with op code,
// two combinational read ports and the registered wrap flag.
interface register_bank_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             wr_en;
  logic [1:0]       wr_op;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             carry;

  modport master (
    output wr_en, wr_op, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, carry
  );

  modport slave (
    input  wr_en, wr_op, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, carry
  );
endinterface

// File: rtl/register_bank.sv
// General-purpose register bank: one LOAD/INC/CLR write port, two
// combinational read ports, optional write-through bypass and hardwired R0.
module register_bank #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter bit BYPASS  = 1'b0,
  parameter bit ZERO_R0 = 1'b0
) (
  input logic            clk,
  input logic            rst,
  register_bank_if.slave bus
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_CLR  = 2'b11
  } wr_op_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             carry_q;

  wr_op_e           op;
  logic             wr_in_range;
  logic             wr_hits_r0;
  logic             accept;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] next_val;
  logic             next_carry;

  assign op          = wr_op_e'(bus.wr_op);
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign wr_hits_r0  = ZERO_R0 && (bus.wr_addr == '0);
  // Gating with rst keeps the bypass path quiet while reset is held.
  assign accept      = rst && bus.wr_en && (op != OP_NOP) && wr_in_range && !wr_hits_r0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    old_val    = '0;
    next_val   = '0;
    next_carry = 1'b0;
    if (wr_in_range) old_val = regs[bus.wr_addr];
    case (op)
      OP_LOAD: next_val = bus.wr_data;
      OP_INC: begin
        next_val   = old_val + WIDTH'(1);
        next_carry = &old_val;
      end
      default: next_val = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the bank is a handful of flops rather than a RAM macro, so clearing every entry on reset is legitimate here.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      regs[bus.wr_addr] <= next_val;
      carry_q           <= next_carry;
    end
  end

  assign bus.carry = carry_q;

  logic [AW-1:0] rd_addr [2];
  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] data;
    always_comb begin
      data = '0;
      if ({1'b0, rd_addr[p]} >= DEPTH_L)
        data = '0;
      else if (ZERO_R0 && (rd_addr[p] == '0))
        data = '0;
      else if (BYPASS && accept && (bus.wr_addr == rd_addr[p]))
        data = next_val;
      else
        data = regs[rd_addr[p]];
    end
  end

  assign bus.rd_data_a = g_rd[0].data;
  assign bus.rd_data_b = g_rd[1].data;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench: three register_bank variants share one stimulus stream
// and are compared against an array-based model of the bank's rules.
module tb_register_bank;

  localparam int         N    = 3;
  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] INC  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_op;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_a;
  logic [1:0] rd_b;

  always #5 clk = ~clk;

  register_bank_if #(.WIDTH(8), .AW(2)) bus0 ();
  register_bank_if #(.WIDTH(8), .AW(2)) bus1 ();
  register_bank_if #(.WIDTH(8), .AW(2)) bus2 ();

  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;   assign bus2.wr_en = wr_en;
  assign bus0.wr_op = wr_op;   assign bus1.wr_op = wr_op;   assign bus2.wr_op = wr_op;
  assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr; assign bus2.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
  assign bus0.rd_addr_a = rd_a; assign bus1.rd_addr_a = rd_a; assign bus2.rd_addr_a = rd_a;
  assign bus0.rd_addr_b = rd_b; assign bus1.rd_addr_b = rd_b; assign bus2.rd_addr_b = rd_b;

  // dut0: plain, dut1: write-through bypass, dut2: three entries with hardwired R0.
  register_bank #(.WIDTH(8), .DEPTH(4), .AW(2), .BYPASS(1'b0), .ZERO_R0(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  register_bank #(.WIDTH(8), .DEPTH(4), .AW(2), .BYPASS(1'b1), .ZERO_R0(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  register_bank #(.WIDTH(8), .DEPTH(3), .AW(2), .BYPASS(1'b0), .ZERO_R0(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic [N-1:0][7:0] act_a;
  logic [N-1:0][7:0] act_b;
  logic [N-1:0]      act_c;
  assign act_a[0] = bus0.rd_data_a; assign act_a[1] = bus1.rd_data_a; assign act_a[2] = bus2.rd_data_a;
  assign act_b[0] = bus0.rd_data_b; assign act_b[1] = bus1.rd_data_b; assign act_b[2] = bus2.rd_data_b;
  assign act_c[0] = bus0.carry;     assign act_c[1] = bus1.carry;     assign act_c[2] = bus2.carry;

  // ---------------- reference model ----------------
  int m_mem   [N][4];
  bit m_carry [N];

  function automatic int cfg_depth(int k);
    return (k == 2) ? 3 : 4;
  endfunction
  function automatic bit cfg_bypass(int k);
    return (k == 1);
  endfunction
  function automatic bit cfg_zero(int k);
    return (k == 2);
  endfunction

  function automatic bit m_accept(int k);
    return rst && wr_en && (wr_op != NOP) && (int'(wr_addr) < cfg_depth(k))
           && !(cfg_zero(k) && wr_addr == 2'd0);
  endfunction

  function automatic int m_next(int k);
    case (wr_op)
      LOAD:    return int'(wr_data);
      INC:     return (m_mem[k][wr_addr] + 1) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic int m_read(int k, int ra);
    if (!rst) return 0;
    if (ra >= cfg_depth(k)) return 0;
    if (cfg_zero(k) && ra == 0) return 0;
    if (cfg_bypass(k) && m_accept(k) && int'(wr_addr) == ra) return m_next(k);
    return m_mem[k][ra];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 4; r++) m_mem[k][r] = 0;
      m_carry[k] = 1'b0;
    end
  endtask

  task automatic m_commit();
    for (int k = 0; k < N; k++) begin
      if (m_accept(k)) begin
        m_carry[k] = (wr_op == INC) && (m_mem[k][wr_addr] == 255);
        m_mem[k][wr_addr] = m_next(k);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [N-1:0][7:0] a;
    logic [N-1:0][7:0] b;
    logic [N-1:0]      c;
    logic [15:0]       id;
  } exp_t;

  exp_t exp_q [$];
  int   sid     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.a[k] = 8'(m_read(k, int'(rd_a)));
      e.b[k] = 8'(m_read(k, int'(rd_b)));
      e.c[k] = rst ? m_carry[k] : 1'b0;
    end
    e.id = 16'(sid);
    sid++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < N; k++) begin
          check($sformatf("s%0d dut%0d rd_a", e.id, k), 32'(act_a[k]), 32'(e.a[k]));
          check($sformatf("s%0d dut%0d rd_b", e.id, k), 32'(act_b[k]), 32'(e.b[k]));
          check($sformatf("s%0d dut%0d carry", e.id, k), 32'(act_c[k]), 32'(e.c[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic [1:0] op, input logic [1:0] addr,
                       input logic [7:0] data, input logic [1:0] ra, input logic [1:0] rb);
    wr_en = en; wr_op = op; wr_addr = addr; wr_data = data; rd_a = ra; rd_b = rb;
  endtask

  task automatic step(input logic en, input logic [1:0] op, input logic [1:0] addr,
                      input logic [7:0] data, input logic [1:0] ra, input logic [1:0] rb);
    @(negedge clk);
    drive(en, op, addr, data, ra, rb);
    push_exp();
    m_commit();
  endtask

  // Reset is asserted between edges with the write port still driven; it must win.
  task automatic do_reset(input logic en, input logic [1:0] op, input logic [1:0] addr,
                          input logic [7:0] data, input logic [1:0] ra, input logic [1:0] rb);
    @(negedge clk);
    drive(en, op, addr, data, ra, rb);
    rst = 1'b0;
    m_reset();
    push_exp();
    @(negedge clk);
    wr_en = 1'b0;
    push_exp();
    rst = 1'b1;
  endtask

  initial begin : stimulus
    logic [7:0] d;
    rst = 1'b0;
    drive(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd1);
    m_reset();

    do_reset(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd1);
    step(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd1);
    step(1'b0, NOP, 2'd0, 8'h00, 2'd2, 2'd3);

    step(1'b1, LOAD, 2'd1, 8'h33, 2'd0, 2'd0);
    step(1'b1, LOAD, 2'd2, 8'hCC, 2'd1, 2'd2);
    step(1'b0, LOAD, 2'd1, 8'h55, 2'd1, 2'd2);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd1, 2'd2);

    step(1'b1, LOAD, 2'd3, 8'hFE, 2'd3, 2'd0);
    step(1'b1, INC,  2'd3, 8'h00, 2'd3, 2'd0);
    step(1'b1, INC,  2'd3, 8'h00, 2'd3, 2'd0);
    step(1'b1, INC,  2'd3, 8'h00, 2'd3, 2'd0);
    step(1'b1, NOP,  2'd3, 8'h00, 2'd3, 2'd0);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd3, 2'd0);

    step(1'b1, LOAD, 2'd0, 8'h7A, 2'd0, 2'd1);
    step(1'b1, CLR,  2'd0, 8'h00, 2'd0, 2'd1);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd0, 2'd1);

    step(1'b1, LOAD, 2'd2, 8'h5A, 2'd2, 2'd2);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd2, 2'd2);

    step(1'b1, LOAD, 2'd0, 8'hAA, 2'd0, 2'd0);
    step(1'b1, INC,  2'd0, 8'h00, 2'd0, 2'd0);
    step(1'b1, LOAD, 2'd3, 8'hAA, 2'd3, 2'd0);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd3, 2'd0);

    step(1'b1, LOAD, 2'd1, 8'h44, 2'd1, 2'd1);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd1, 2'd1);
    do_reset(1'b1, LOAD, 2'd1, 8'h99, 2'd1, 2'd1);
    step(1'b0, NOP,  2'd0, 8'h00, 2'd1, 2'd2);

    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 49) == 0)
        do_reset(1'($urandom), 2'($urandom), 2'($urandom), d, 2'($urandom), 2'($urandom));
      else
        step(($urandom_range(0, 7) != 0), 2'($urandom), 2'($urandom), d,
             2'($urandom), 2'($urandom));
    end

    @(negedge clk);
    drive(1'b0, NOP, 2'd0, 8'h00, 2'd0, 2'd0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, for the processor datapath.
- Successor to the single load-enabled register: one write port with an operation code (load / increment / clear), two combinational read ports, optional write-through bypass, optional hardwired-zero R0, and a registered wrap (carry) flag.
- Sits between the datapath bus and the ALU operand muxes.

Parameters:
- WIDTH, 8, data width of each register (>=2).
- DEPTH, 4, number of registers (>=2, <=2**AW).
- AW, 2, address width of all address ports.
- BYPASS, 0, 1 = read ports show the value being written this cycle; 0 = read ports show stored contents only.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- wr_en, input, 1, write-port enable, sampled on the rising edge of clk.
- wr_op, input, 2, 00 NOP, 01 LOAD, 10 INC, 11 CLR.
- wr_addr, input, AW, target register.
- wr_data, input, WIDTH, LOAD operand.
- rd_addr_a, input, AW, read port A address.
- rd_addr_b, input, AW, read port B address.
- rd_data_a, output, WIDTH, read port A data (combinational).
- rd_data_b, output, WIDTH, read port B data (combinational).
- carry, output, 1, registered wrap flag of the last accepted operation.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - All registers 0 and carry 0, immediately.
  - Therefore rd_data_a and rd_data_b are 0 while rst is held low.
  - Release is synchronous in effect: the first write is accepted on the first rising edge with rst=1.
- Accepted op: wr_en=1, wr_op!=00, wr_addr<DEPTH, and not (ZERO_R0=1 and wr_addr=0). Takes effect at that rising edge, 1-cycle latency.
  - LOAD: reg[wr_addr] <= wr_data; carry <= 0.
  - INC: reg[wr_addr] <= reg[wr_addr]+1 modulo 2**WIDTH; carry <= 1 if the old value was all ones, else 0.
  - CLR: reg[wr_addr] <= 0; carry <= 0.
- Non-accepted cycle: all registers and carry hold. This covers wr_en=0, NOP, out-of-range address, or the R0 write when ZERO_R0=1.
- Only one register changes per cycle; all other registers always hold.
- Reads, identical rules for ports A and B, evaluated independently:
  - Address >= DEPTH -> 0.
  - ZERO_R0=1 and address 0 -> 0.
  - BYPASS=1 and the current cycle holds an accepted op to the same address -> the next value (LOAD: wr_data; INC: reg+1 wrapped; CLR: 0).
  - Otherwise -> stored reg[address].
- Both ports may read the same address; both ports may equal wr_addr.
- BYPASS=0: a read of wr_addr returns the old value until after the edge.
- carry is not bypassed; it always reflects the last accepted op's registered result.
- Reset asserted mid-cycle with wr_en=1 overrides the write; nothing is stored.

Test Plan:
- Reset: rst=0 at t=0, then release; read all addresses -> 0, carry=0. Then LOAD R1=0x33 and assert rst=0 between edges -> R1 reads 0x00 immediately.
- Load/read (WIDTH=8, DEPTH=4):
  - LOAD R1=0x33, LOAD R2=0xCC, then rd_addr_a=1, rd_addr_b=2 -> 0x33, 0xCC.
  - Next cycle wr_en=0 with wr_data=0x55 -> R1 and R2 unchanged.
- Increment wrap:
  - LOAD R3=0xFE; INC R3 -> 0xFF, carry=0.
  - INC R3 -> 0x00, carry=1.
  - INC R3 -> 0x01, carry=0.
  - NOP -> carry holds 0.
- Clear: LOAD R0=0x7A, CLR R0 -> R0 reads 0x00, carry=0; R1 still 0x33.
- Bypass:
  - BYPASS=1: LOAD R2=0x5A while rd_addr_a=2 -> rd_data_a=0x5A in the same cycle.
  - BYPASS=0, same stimulus -> rd_data_a shows the old 0xCC until after the edge, then 0x5A.
- ZERO_R0=1:
  - LOAD R0=0xAA then INC R0 -> R0 reads 0x00 and carry unchanged.
  - Write to address 3 with DEPTH=3 -> ignored; read of address 3 returns 0.
